// File: rtl/contador_pkg.sv
// Shared definitions for the arbiter in front of the external up/down counter:
// FSM state encoding, default counter reset value and legal range.
package contador_pkg;

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        EXECUTA = 2'd1,
        PAUSA   = 2'd2
    } estado_t;

    localparam int VAL_INI_DEF = 106;
    localparam int LIM_MIN_DEF = 0;
    localparam int LIM_MAX_DEF = 255;

    // Width of a requester index; at least one bit even for a single requester.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/arbitro_contador_seletor_rr.sv
// Round-robin selector: the search starts just after the last winner and
// ascends with wrap-around. Purely combinational.
module seletor_rr
    import contador_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int W     = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [W-1:0]     last_winner,
    output logic [W-1:0]     winner,
    output logic             valid
);

    // w_idx[k] is the requester examined k-th in this round.
    logic [W-1:0] w_idx [N_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_ordem
            assign w_idx[gi] = W'((int'(last_winner) + 1 + gi) % N_REQ);
        end
    endgenerate

    // Walk the order backwards so the earliest requester in the order wins.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req[w_idx[k]]) begin
                winner = w_idx[k];
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/arbitro_contador.sv
// Arbiter that serialises increment/decrement requests towards an external
// counter, refusing requests that would push it outside [LIM_MIN, LIM_MAX],
// and keeps a shadow copy of the counter value. All outputs are registered.
module arbitro_contador
    import contador_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int VAL_INI = VAL_INI_DEF,
    parameter int LIM_MIN = LIM_MIN_DEF,
    parameter int LIM_MAX = LIM_MAX_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] dir,
    output logic [N_REQ-1:0] gnt,
    output logic [N_REQ-1:0] rej,
    output logic             acrescer,
    output logic             decrescer,
    output logic [7:0]       valor
);

    localparam int             W         = idx_width(N_REQ);
    localparam logic [7:0]     C_INI     = 8'(VAL_INI);
    localparam logic [7:0]     C_MIN     = 8'(LIM_MIN);
    localparam logic [7:0]     C_MAX     = 8'(LIM_MAX);
    // Last winner starts at the top index so requester 0 is searched first.
    localparam logic [W-1:0]   C_ULT_INI = W'(N_REQ - 1);

    estado_t          r_estado, r_estado_next;
    logic [W-1:0]     r_venc, r_venc_next;
    logic [W-1:0]     r_ultimo, r_ultimo_next;
    logic             r_dir, r_dir_next;
    logic [N_REQ-1:0] r_gnt, r_gnt_next;
    logic [N_REQ-1:0] r_rej, r_rej_next;
    logic             r_acr, r_acr_next;
    logic             r_dec, r_dec_next;
    logic [7:0]       r_valor, r_valor_next;

    logic [W-1:0]     w_venc;
    logic             w_valido;
    logic             w_dir_venc;

    seletor_rr #(
        .N_REQ (N_REQ),
        .W     (W)
    ) u_seletor (
        .req         (req),
        .last_winner (r_ultimo),
        .winner      (w_venc),
        .valid       (w_valido)
    );

    assign w_dir_venc = dir[w_venc];

    // Next state and next outputs. The grant/refuse decision is taken when the
    // request is latched so that gnt/rej and the strobe come out of flops during
    // EXECUTA; valor cannot change between latching and EXECUTA, so the limit
    // test sees the same value the service acts on.
    always_comb begin
        r_estado_next = r_estado;
        r_venc_next   = r_venc;
        r_ultimo_next = r_ultimo;
        r_dir_next    = r_dir;
        r_gnt_next    = '0;
        r_rej_next    = '0;
        r_acr_next    = 1'b0;
        r_dec_next    = 1'b0;
        r_valor_next  = r_valor;

        case (r_estado)
            OCIOSO: begin
                if (w_valido) begin
                    r_venc_next   = w_venc;
                    r_dir_next    = w_dir_venc;
                    r_estado_next = EXECUTA;
                    if (w_dir_venc) begin
                        if (r_valor < C_MAX) begin
                            r_gnt_next[w_venc] = 1'b1;
                            r_acr_next         = 1'b1;
                        end else begin
                            r_rej_next[w_venc] = 1'b1;
                        end
                    end else begin
                        if (r_valor > C_MIN) begin
                            r_gnt_next[w_venc] = 1'b1;
                            r_dec_next         = 1'b1;
                        end else begin
                            r_rej_next[w_venc] = 1'b1;
                        end
                    end
                end
            end
            EXECUTA: begin
                // Shadow follows the counter only when a strobe was actually sent.
                if (r_gnt != '0) begin
                    r_valor_next = r_dir ? (r_valor + 8'd1) : (r_valor - 8'd1);
                end
                r_ultimo_next = r_venc;
                r_estado_next = PAUSA;
            end
            PAUSA: begin
                r_estado_next = OCIOSO;
            end
            default: begin
                r_estado_next = OCIOSO;
            end
        endcase
    end

    // State, latched request and registered outputs; reset aborts any service.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_estado <= OCIOSO;
            r_venc   <= '0;
            r_ultimo <= C_ULT_INI;
            r_dir    <= 1'b0;
            r_gnt    <= '0;
            r_rej    <= '0;
            r_acr    <= 1'b0;
            r_dec    <= 1'b0;
            r_valor  <= C_INI;
        end else begin
            r_estado <= r_estado_next;
            r_venc   <= r_venc_next;
            r_ultimo <= r_ultimo_next;
            r_dir    <= r_dir_next;
            r_gnt    <= r_gnt_next;
            r_rej    <= r_rej_next;
            r_acr    <= r_acr_next;
            r_dec    <= r_dec_next;
            r_valor  <= r_valor_next;
        end
    end

    assign gnt       = r_gnt;
    assign rej       = r_rej;
    assign acrescer  = r_acr;
    assign decrescer = r_dec;
    assign valor     = r_valor;

endmodule

// File: tb/tb_arbitro_contador.sv
// Directed bench: one arbiter with default limits and one with [105,108],
// both driven by the same requests, each paired with a counter model.
module tb_arbitro_contador;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         rst_n;
    logic [N-1:0] req, dir;
    logic [N-1:0] gnt, rej, gnt_l, rej_l;
    logic         acr, dec, acr_l, dec_l;
    logic [7:0]   valor, valor_l;
    logic [7:0]   saida, saida_l;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    bit sb_en   = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign rst_n = ~rst;

    arbitro_contador #(.N_REQ(N)) dut (
        .clk(clk), .rst(rst), .req(req), .dir(dir),
        .gnt(gnt), .rej(rej), .acrescer(acr), .decrescer(dec), .valor(valor)
    );

    arbitro_contador #(.N_REQ(N), .VAL_INI(106), .LIM_MIN(105), .LIM_MAX(108)) dut_l (
        .clk(clk), .rst(rst), .req(req), .dir(dir),
        .gnt(gnt_l), .rej(rej_l), .acrescer(acr_l), .decrescer(dec_l), .valor(valor_l)
    );

    // External counters (active-low reset tied to ~rst), driven by the strobes.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) saida <= 8'd106;
        else if (acr) saida <= saida + 8'd1;
        else if (dec) saida <= saida - 8'd1;
    end
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) saida_l <= 8'd106;
        else if (acr_l) saida_l <= saida_l + 8'd1;
        else if (dec_l) saida_l <= saida_l - 8'd1;
    end

    // Scoreboard: shadow equals counter, no strobe overlap, at most one gnt/rej bit.
    always @(negedge clk) begin
        if (sb_en) begin
            n_total++;
            if (valor !== saida) $display("FAIL sb_valor t=%0t valor=%0d saida=%0d", $time, valor, saida);
            else n_pass++;
            n_total++;
            if (valor_l !== saida_l) $display("FAIL sb_valor_l t=%0t valor=%0d saida=%0d", $time, valor_l, saida_l);
            else n_pass++;
            n_total++;
            if ((acr & dec) !== 1'b0 || (acr_l & dec_l) !== 1'b0)
                $display("FAIL sb_overlap t=%0t acr/dec=%b%b lim=%b%b required no overlap", $time, acr, dec, acr_l, dec_l);
            else n_pass++;
            n_total++;
            if ($countones({gnt, rej}) > 1 || $countones({gnt_l, rej_l}) > 1)
                $display("FAIL sb_onehot t=%0t gnt=%b rej=%b lim gnt=%b rej=%b", $time, gnt, rej, gnt_l, rej_l);
            else n_pass++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Steps negedges until either DUT shows gnt/rej; at = cycle number or -1.
    task automatic wait_service(input int budget, output int at);
        bit found = 1'b0;
        at = -1;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk);
            if ((gnt | rej | gnt_l | rej_l) != '0) begin
                at    = cyc;
                found = 1'b1;
            end
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        #1 rst = 1'b1; req = '0; dir = '0;
        @(negedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = '0; dir = '0;
        repeat (3) @(negedge clk);
        n_total++;
        if (gnt !== 4'b0 || rej !== 4'b0 || acr !== 1'b0 || dec !== 1'b0)
            $display("FAIL reset_outputs gnt=%b rej=%b acr=%b dec=%b required all 0", gnt, rej, acr, dec);
        else n_pass++;
        n_total++;
        if (valor !== 8'd106 || valor_l !== 8'd106)
            $display("FAIL reset_valor valor=%0d lim=%0d required 106", valor, valor_l);
        else n_pass++;
        #1 rst = 1'b0;
        sb_en = 1'b1;
    endtask

    task automatic test_single_inc();
        int c0, at;
        @(negedge clk);
        #1 req = 4'b0001; dir = 4'b0001;
        c0 = cyc;
        wait_service(4, at);
        n_total++;
        if (at != c0 + 1) $display("FAIL inc_latency at=%0d required %0d", at, c0 + 1);
        else n_pass++;
        n_total++;
        if (gnt !== 4'b0001 || rej !== 4'b0 || acr !== 1'b1 || dec !== 1'b0 || gnt_l !== 4'b0001)
            $display("FAIL inc_grant gnt=%b rej=%b acr=%b dec=%b gnt_l=%b required 0001/0000/1/0/0001",
                     gnt, rej, acr, dec, gnt_l);
        else n_pass++;
        n_total++;
        if (valor !== 8'd106) $display("FAIL inc_valor_before valor=%0d required 106", valor);
        else n_pass++;
        // Changing req/dir mid-service must not alter it.
        #1 req = 4'b0000; dir = 4'b0000;
        @(negedge clk);
        n_total++;
        if (gnt !== 4'b0 || acr !== 1'b0 || valor !== 8'd107 || valor_l !== 8'd107)
            $display("FAIL inc_pausa gnt=%b acr=%b valor=%0d lim=%0d required 0000/0/107/107",
                     gnt, acr, valor, valor_l);
        else n_pass++;
        repeat (2) @(negedge clk);
        n_total++;
        if (gnt !== 4'b0 || rej !== 4'b0 || valor !== 8'd107)
            $display("FAIL inc_idle gnt=%b rej=%b valor=%0d required 0000/0000/107", gnt, rej, valor);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp_w [5];
        int at, prev;
        exp_w[0] = 4'b0001; exp_w[1] = 4'b0010; exp_w[2] = 4'b0100;
        exp_w[3] = 4'b1000; exp_w[4] = 4'b0001;
        apply_reset();
        req = 4'b1111; dir = 4'b1111;
        prev = 0;
        for (int s = 0; s < 5; s++) begin
            wait_service(6, at);
            n_total++;
            if (at < 0) $display("FAIL rr_timeout service=%0d", s);
            else n_pass++;
            n_total++;
            if (gnt !== exp_w[s] || acr !== 1'b1)
                $display("FAIL rr_order service=%0d gnt=%b acr=%b required %b/1", s, gnt, acr, exp_w[s]);
            else n_pass++;
            if (s > 0) begin
                n_total++;
                if (at - prev != 3) $display("FAIL rr_spacing service=%0d spacing=%0d required 3", s, at - prev);
                else n_pass++;
            end
            // Limited DUT: 106->107->108, then refusals without strobe.
            n_total++;
            if (s < 2) begin
                if (gnt_l !== exp_w[s] || rej_l !== 4'b0 || acr_l !== 1'b1)
                    $display("FAIL rr_lim service=%0d gnt_l=%b rej_l=%b acr_l=%b required %b/0000/1",
                             s, gnt_l, rej_l, acr_l, exp_w[s]);
                else n_pass++;
            end else begin
                if (rej_l !== exp_w[s] || gnt_l !== 4'b0 || acr_l !== 1'b0)
                    $display("FAIL rr_lim service=%0d gnt_l=%b rej_l=%b acr_l=%b required 0000/%b/0",
                             s, gnt_l, rej_l, acr_l, exp_w[s]);
                else n_pass++;
            end
            prev = at;
        end
        #1 req = '0; dir = '0;
        @(negedge clk);
        n_total++;
        if (valor !== 8'd111 || valor_l !== 8'd108)
            $display("FAIL rr_valor valor=%0d lim=%0d required 111/108", valor, valor_l);
        else n_pass++;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_limit_max();
        int at;
        logic [7:0] exp_v [3];
        exp_v[0] = 8'd106; exp_v[1] = 8'd107; exp_v[2] = 8'd108;
        apply_reset();
        req = 4'b0001; dir = 4'b0001;
        for (int s = 0; s < 3; s++) begin
            wait_service(6, at);
            n_total++;
            if (at < 0) $display("FAIL max_timeout service=%0d", s);
            else n_pass++;
            n_total++;
            if (valor_l !== exp_v[s]) $display("FAIL max_valor service=%0d valor_l=%0d required %0d", s, valor_l, exp_v[s]);
            else n_pass++;
            n_total++;
            if (s < 2) begin
                if (gnt_l !== 4'b0001 || acr_l !== 1'b1 || rej_l !== 4'b0)
                    $display("FAIL max_grant service=%0d gnt_l=%b acr_l=%b rej_l=%b required 0001/1/0000",
                             s, gnt_l, acr_l, rej_l);
                else n_pass++;
            end else begin
                if (rej_l !== 4'b0001 || acr_l !== 1'b0 || gnt_l !== 4'b0 || gnt !== 4'b0001)
                    $display("FAIL max_reject rej_l=%b acr_l=%b gnt_l=%b gnt=%b required 0001/0/0000/0001",
                             rej_l, acr_l, gnt_l, gnt);
                else n_pass++;
            end
        end
        #1 req = '0; dir = '0;
        @(negedge clk);
        n_total++;
        if (valor_l !== 8'd108 || valor !== 8'd109)
            $display("FAIL max_final valor_l=%0d valor=%0d required 108/109", valor_l, valor);
        else n_pass++;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_limit_min();
        int at;
        apply_reset();
        req = 4'b0010; dir = 4'b0000;
        wait_service(6, at);
        n_total++;
        if (at < 0 || gnt_l !== 4'b0010 || dec_l !== 1'b1 || acr_l !== 1'b0 || rej_l !== 4'b0)
            $display("FAIL min_grant at=%0d gnt_l=%b dec_l=%b acr_l=%b rej_l=%b required 0010/1/0/0000",
                     at, gnt_l, dec_l, acr_l, rej_l);
        else n_pass++;
        wait_service(6, at);
        n_total++;
        if (at < 0 || rej_l !== 4'b0010 || dec_l !== 1'b0 || gnt_l !== 4'b0 || valor_l !== 8'd105)
            $display("FAIL min_reject at=%0d rej_l=%b dec_l=%b gnt_l=%b valor_l=%0d required 0010/0/0000/105",
                     at, rej_l, dec_l, gnt_l, valor_l);
        else n_pass++;
        n_total++;
        if (gnt !== 4'b0010 || dec !== 1'b1)
            $display("FAIL min_main gnt=%b dec=%b required 0010/1", gnt, dec);
        else n_pass++;
        #1 req = '0;
        @(negedge clk);
        n_total++;
        if (valor_l !== 8'd105 || valor !== 8'd104)
            $display("FAIL min_final valor_l=%0d valor=%0d required 105/104", valor_l, valor);
        else n_pass++;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int at;
        apply_reset();
        req = 4'b0100; dir = 4'b0100;
        wait_service(6, at);
        wait_service(6, at);
        n_total++;
        if (at < 0 || gnt !== 4'b0100 || acr !== 1'b1 || valor !== 8'd107)
            $display("FAIL mid_setup at=%0d gnt=%b acr=%b valor=%0d required 0100/1/107", at, gnt, acr, valor);
        else n_pass++;
        #1 rst = 1'b1;
        #1;
        n_total++;
        if (gnt !== 4'b0 || rej !== 4'b0 || acr !== 1'b0 || dec !== 1'b0 || valor !== 8'd106)
            $display("FAIL mid_async gnt=%b rej=%b acr=%b dec=%b valor=%0d required 0000/0000/0/0/106",
                     gnt, rej, acr, dec, valor);
        else n_pass++;
        req = 4'b1111; dir = 4'b1111;
        @(negedge clk);
        #1 rst = 1'b0;
        wait_service(6, at);
        n_total++;
        if (at < 0 || gnt !== 4'b0001 || valor !== 8'd106)
            $display("FAIL mid_next_winner at=%0d gnt=%b valor=%0d required 0001/106", at, gnt, valor);
        else n_pass++;
        #1 req = '0; dir = '0;
        repeat (3) @(negedge clk);
        n_total++;
        if (valor !== 8'd107) $display("FAIL mid_final valor=%0d required 107", valor);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_inc();
        test_round_robin();
        test_limit_max();
        test_limit_min();
        test_reset_mid();
        @(negedge clk);
        sb_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/arbitro_contador.md
ARBITRO_CONTADOR -- requirements
Module: arbitro_contador

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, number of requesters.
REQ-002 The block SHALL have parameter VAL_INI, default 106, shadow value after reset; it equals the counter's own reset value.
REQ-003 The block SHALL have parameters LIM_MIN, default 0, and LIM_MAX, default 255, giving the inclusive legal range of the counter value.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 req  input  N_REQ  per-requester request, level, held until gnt or rej.
REQ-007 dir  input  N_REQ  per-requester direction: 1 = increment, 0 = decrement; valid while the matching req is high.
REQ-008 gnt  output  N_REQ  one-hot, one-cycle pulse: request executed.
REQ-009 rej  output  N_REQ  one-hot, one-cycle pulse: request refused because the limit was reached.
REQ-010 acrescer  output  1  one-cycle increment strobe to the counter.
REQ-011 decrescer  output  1  one-cycle decrement strobe to the counter.
REQ-012 valor  output  8  shadow copy of the counter value.

Function
REQ-013 FSM states SHALL be OCIOSO, EXECUTA and PAUSA.
REQ-014 OCIOSO: if any req bit is high, the winner and its dir SHALL be latched, with the next state EXECUTA; otherwise the FSM SHALL stay in OCIOSO.
REQ-015 Winner selection SHALL be round-robin: search starts at index (last_winner+1) mod N_REQ and ascends with wrap.
REQ-016 EXECUTA, latched dir=1, valor<LIM_MAX: acrescer=1 and gnt[winner]=1 for this cycle, and valor SHALL be incremented by 1 at the closing edge.
REQ-017 EXECUTA, latched dir=0, valor>LIM_MIN: decrescer=1 and gnt[winner]=1 for this cycle, and valor SHALL be decremented by 1 at the closing edge.
REQ-018 EXECUTA at the limit (dir=1 with valor==LIM_MAX, or dir=0 with valor==LIM_MIN): rej[winner]=1 for this cycle, with no strobe and valor unchanged; the counter SHALL never wrap through this block.
REQ-019 On leaving EXECUTA, last_winner SHALL be updated to the winner, and the next state SHALL be PAUSA.
REQ-020 PAUSA SHALL last exactly one cycle with all outputs except valor at 0, then return to OCIOSO; this gives the requester one cycle to drop req.
REQ-021 acrescer and decrescer SHALL never be high together; at most one gnt/rej bit SHALL be high in any cycle.
REQ-022 Latency: req first sampled high in OCIOSO at edge k → gnt/rej and strobe in cycle k+1 → new valor visible after edge k+1; minimum spacing between services is 3 cycles.
REQ-023 A req dropped before it is sampled in OCIOSO SHALL be ignored; req/dir changes during EXECUTA or PAUSA SHALL not affect the service in progress.
REQ-024 A requester still holding req in OCIOSO after its gnt SHALL be treated as a new request.
REQ-025 All outputs SHALL be registered, with no combinational path from req/dir to any output.

Reset
REQ-026 rst=1 SHALL force, asynchronously: state OCIOSO, gnt=0, rej=0, acrescer=0, decrescer=0, valor=VAL_INI, last_winner=N_REQ-1 (so requester 0 has priority first).
REQ-027 Reset during EXECUTA SHALL abort the service: no gnt/rej is issued and valor=VAL_INI.
REQ-028 The counter's active-low reset SHALL be driven as the inverse of rst at the integration level, so the two stay coherent.

Structure
REQ-029 The FSM state encoding and the default values of VAL_INI, LIM_MIN and LIM_MAX SHALL live in shared package contador_pkg.
REQ-030 The round-robin selector SHALL be one sub-module, seletor_rr (inputs req and last_winner; output winner index and valid flag).
REQ-031 arbitro_contador SHALL instantiate seletor_rr and contain the FSM and shadow register; Contador stays external.

Verification
REQ-032 After reset, req=0001, dir=0001 → gnt=0001 and acrescer one cycle later, then valor=107.
REQ-033 req=1111 held continuously → grant order 0,1,2,3,0 with 3-cycle spacing.
REQ-034 LIM_MAX=108, repeated increments from 106 → two gnt pulses, then a rej pulse with no acrescer, and valor stays 108.
REQ-035 LIM_MIN=105, decrements → one gnt, then rej, with valor stays 105 and no decrescer.
REQ-036 rst asserted mid-EXECUTA → outputs 0 immediately, valor=106, and requester 0 wins next.
REQ-037 A bench scoreboard SHALL check that valor always equals Contador.saida and that no strobe overlap occurs.
